// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one handshaked memory port between fetch and data paths,
// stalling the pipeline until every pending access of the cycle is served.
module sram_port_arbiter #(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        stallreq,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_sel, r_wr, r_inst_done, r_data_done, r_bus_err;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr, r_wdata, r_inst_rdata, r_data_rdata, r_cnt;
  logic        w_inst_pend, w_data_pend, w_resp_ok, w_timeout, w_fin, w_issue;
  assign w_inst_pend = inst_en & ~r_inst_done;
  assign w_data_pend = data_en & ~r_data_done;
  assign w_resp_ok   = (r_state == RESP) & mem_data_ok;
  assign w_timeout   = (TIMEOUT_CYC > 0) && (r_state == RESP) && !mem_data_ok && (r_cnt == 32'(TIMEOUT_CYC));
  assign w_fin       = w_resp_ok | w_timeout;
  assign w_issue     = (r_state == IDLE) & (w_inst_pend | w_data_pend);
  always_comb begin
    w_next = r_state;
    if (w_issue) w_next = REQ;
    else if (r_state == REQ && mem_addr_ok) w_next = RESP;
    else if (w_fin) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_wr         <= 1'b0;
      r_wstrb      <= 4'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_inst_rdata <= 32'd0;
      r_data_rdata <= 32'd0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_cnt        <= 32'd0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      // data side wins arbitration: it belongs to the older instruction
      if (w_issue) begin
        r_sel   <= w_data_pend;
        r_wr    <= w_data_pend & (|data_wen);
        r_wstrb <= w_data_pend ? data_wen : 4'd0;
        r_addr  <= w_data_pend ? data_addr : inst_addr;
        r_wdata <= w_data_pend ? data_wdata : 32'd0;
      end
      r_cnt <= (r_state == RESP && !w_fin) ? r_cnt + 32'd1 : 32'd0;
      if (w_timeout) r_bus_err <= 1'b1;
      r_inst_done <= (w_fin & ~r_sel) | (stall_in & r_inst_done);
      r_data_done <= (w_fin & r_sel) | (stall_in & r_data_done);
      if (w_resp_ok & ~r_sel) r_inst_rdata <= mem_rdata;
      if (w_resp_ok & r_sel & ~r_wr) r_data_rdata <= mem_rdata;
    end
  end
  assign stallreq   = w_inst_pend | w_data_pend | (r_state != IDLE);
  assign mem_req    = (r_state == REQ);
  assign mem_wr     = r_wr;
  assign mem_wstrb  = r_wstrb;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;
  assign bus_err    = r_bus_err;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench with a request/response scoreboard and a
// bench-side memory responder driving the handshake.
module tb_sram_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1, hold = 1'b0;
  logic        stall_in, inst_en = 1'b0, data_en = 1'b0, stallreq;
  logic [31:0] inst_addr = '0, inst_rdata, data_addr = '0, data_wdata = '0, data_rdata;
  logic [3:0]  data_wen = '0, mem_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok = 1'b0, mem_data_ok = 1'b0, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  int checks = 0, failures = 0, sc = 0, hs = 0, sc0, hs0;
  logic [31:0] exp_ird = '0, exp_drd = '0;
  typedef struct {
    logic        side;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  txn_t q[$];
  assign stall_in = stallreq | hold;
  always #5 clk = ~clk;
  sram_port_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .stallreq(stallreq),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );
  always @(negedge clk) begin
    if (stallreq) sc++;
    if (mem_req && mem_addr_ok) hs++;
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic side, input logic wr, input logic [3:0] wstrb,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.side = side; t.wr = wr; t.wstrb = wstrb; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    q.push_back(t);
  endtask
  task automatic mem_txn(input int aw, input int dw);
    txn_t t;
    int w;
    t = q.pop_front();
    w = 0;
    while (!mem_req && w < 20) begin step; w++; end
    chk("req_seen", {31'd0, mem_req}, 32'd1);
    chk("mem_wr", {31'd0, mem_wr}, {31'd0, t.wr});
    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, t.wstrb});
    chk("mem_addr", mem_addr, t.addr);
    chk("mem_wdata", mem_wdata, t.wdata);
    repeat (aw) begin step; chk("req_hold", {31'd0, mem_req}, 32'd1); end
    mem_addr_ok = 1'b1;
    step;
    mem_addr_ok = 1'b0;
    chk("req_drop", {31'd0, mem_req}, 32'd0);
    repeat (dw - 1) step;
    mem_data_ok = 1'b1;
    mem_rdata = t.rdata;
    step;
    mem_data_ok = 1'b0;
    mem_rdata = '0;
    if (!t.side) exp_ird = t.rdata;
    else if (!t.wr) exp_drd = t.rdata;
    chk("inst_rdata", inst_rdata, exp_ird);
    chk("data_rdata", data_rdata, exp_drd);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    step; step;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b0;
    step; step;
    chk("idle_stallreq", {31'd0, stallreq}, 32'd0);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    // single fetch: data_ok two cycles after addr_ok
    inst_en = 1'b1; inst_addr = 32'hBFC00000;
    push(1'b0, 1'b0, 4'd0, 32'hBFC00000, 32'd0, 32'h3C080001);
    sc0 = sc;
    mem_txn(0, 2);
    inst_en = 1'b0;
    step;
    chk("t1_stall_cycles", sc - sc0, 32'd4);
    chk("t1_inst_rdata", inst_rdata, 32'h3C080001);
    // fetch and load together: load first, one idle cycle, then fetch
    inst_en = 1'b1; inst_addr = 32'hBFC00004;
    data_en = 1'b1; data_wen = 4'd0; data_addr = 32'h80000010;
    push(1'b1, 1'b0, 4'd0, 32'h80000010, 32'd0, 32'hCAFEF00D);
    push(1'b0, 1'b0, 4'd0, 32'hBFC00004, 32'd0, 32'h24020005);
    mem_txn(0, 1);
    #1;
    chk("t2_idle_gap", {31'd0, mem_req}, 32'd0);
    chk("t2_gap_stall", {31'd0, stallreq}, 32'd1);
    step;
    chk("t2_inst_req", {31'd0, mem_req}, 32'd1);
    mem_txn(0, 1);
    #1;
    chk("t2_stall_drop", {31'd0, stallreq}, 32'd0);
    inst_en = 1'b0; data_en = 1'b0;
    step;
    // store: strobes and data forwarded, load buffer untouched
    data_en = 1'b1; data_wen = 4'b0011; data_addr = 32'h80000020; data_wdata = 32'h0000ABCD;
    push(1'b1, 1'b1, 4'b0011, 32'h80000020, 32'h0000ABCD, 32'hDEADBEEF);
    mem_txn(1, 3);
    data_en = 1'b0; data_wen = 4'd0;
    step;
    chk("t3_data_rdata", data_rdata, 32'hCAFEF00D);
    // fetch served during a foreign stall: no re-issue
    hold = 1'b1;
    inst_en = 1'b1; inst_addr = 32'hBFC00008;
    push(1'b0, 1'b0, 4'd0, 32'hBFC00008, 32'd0, 32'h00851021);
    hs0 = hs;
    mem_txn(0, 2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_no_reissue", {31'd0, mem_req}, 32'd0);
      chk("t4_stallreq", {31'd0, stallreq}, 32'd0);
      chk("t4_inst_stable", inst_rdata, 32'h00851021);
      step;
    end
    hold = 1'b0;
    step;
    inst_en = 1'b0;
    step;
    chk("t4_handshakes", hs - hs0, 32'd1);
    chk("t4_inst_rdata", inst_rdata, 32'h00851021);
    // reset in RESP, then a stray data_ok
    inst_en = 1'b1; inst_addr = 32'hBFC0000C;
    step;
    chk("t5_req", {31'd0, mem_req}, 32'd1);
    mem_addr_ok = 1'b1;
    step;
    mem_addr_ok = 1'b0;
    rst = 1'b1; inst_en = 1'b0;
    step;
    rst = 1'b0;
    #1;
    chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_stallreq", {31'd0, stallreq}, 32'd0);
    exp_ird = '0; exp_drd = '0;
    mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    step;
    mem_data_ok = 1'b0; mem_rdata = '0;
    step;
    chk("t5_inst_rdata", inst_rdata, exp_ird);
    chk("t5_data_rdata", data_rdata, exp_drd);
    chk("t5_idle", {31'd0, mem_req}, 32'd0);
    // no data_ok: timeout after the 9th RESP cycle
    inst_en = 1'b1; inst_addr = 32'hBFC00100;
    step;
    mem_addr_ok = 1'b1;
    step;
    mem_addr_ok = 1'b0;
    repeat (8) step;
    #1;
    chk("t6_no_err_yet", {31'd0, bus_err}, 32'd0);
    chk("t6_still_stall", {31'd0, stallreq}, 32'd1);
    step;
    #1;
    chk("t6_bus_err", {31'd0, bus_err}, 32'd1);
    chk("t6_stall_drop", {31'd0, stallreq}, 32'd0);
    chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_inst_rdata", inst_rdata, exp_ird);
    inst_en = 1'b0;
    repeat (3) step;
    chk("t6_sticky", {31'd0, bus_err}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
